// File: rtl/rr_issue_arbiter.sv
// rr_issue_arbiter: round-robin arbiter that shares one resource among N
// requesters, with a registered one-hot/index grant and a valid/ready handshake.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_i[N]      per-requester request
//   lock_i[N]     per-requester lock hint (only when RR_ARB_LOCK_EN is defined)
//   gnt_ready_i   resource accepts the current grant
//   gnt_valid_o   a grant is presented
//   gnt_onehot_o  one-hot grant, zero when idle
//   gnt_idx_o     grant index, zero when idle
//   rr_ptr_o      current priority pointer
//
// Optional feature macro: RR_ARB_LOCK_EN adds lock_i. On a fire whose granted
// requester has both lock and req high, the same requester is granted again
// and the pointer holds.
module rr_issue_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
`ifdef RR_ARB_LOCK_EN
  input  logic [N-1:0]     lock_i,
`endif
  input  logic             gnt_ready_i,
  output logic             gnt_valid_o,
  output logic [N-1:0]     gnt_onehot_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [IDX_W-1:0] rr_ptr_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   NW   = (IDX_W + 1)'(N);
  localparam logic [N-1:0]     ONE  = N'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     oh_q, oh_d;

  logic             fire;
  logic             hold;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] base;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  assign fire = (state_q == GRANT) && gnt_ready_i;

`ifdef RR_ARB_LOCK_EN
  assign hold = fire && lock_i[idx_q] && req_i[idx_q];
`else
  assign hold = 1'b0;
`endif

  // Explicit wrap so non-power-of-two N never leaves the legal range.
  assign ptr_inc = (idx_q == LAST) ? '0 : idx_q + 1'b1;

  // The selection base is the pointer as it will be after this cycle,
  // so a fire re-arbitrates from the advanced pointer in the same cycle.
  always_comb begin
    base = ptr_q;
    if (fire && !hold) base = ptr_inc;
  end

  // Rotated bottom-up priority encode starting at base.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, base} + (IDX_W + 1)'(k);
      if (sum >= NW) sum = sum - NW;
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = win;
        end
      end
      GRANT: begin
        if (fire) begin
          ptr_d = base;
          if (hold) begin
            idx_d = idx_q;
          end else if (found) begin
            idx_d = win;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign oh_d = (state_d == GRANT) ? (ONE << idx_d) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      oh_q    <= oh_d;
    end
  end

  assign gnt_valid_o  = (state_q == GRANT);
  assign gnt_onehot_o = oh_q;
  assign gnt_idx_o    = idx_q;
  assign rr_ptr_o     = ptr_q;

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// tb_rr_issue_arbiter: directed checks of rr_issue_arbiter with N=4 and N=5.
// Expected values are hand-computed constants.
module tb_rr_issue_arbiter;

  logic       clk;
  logic       rst_n;

  logic [3:0] req4;
  logic [3:0] lock4;
  logic       rdy4;
  logic       v4;
  logic [3:0] oh4;
  logic [1:0] idx4;
  logic [1:0] ptr4;

  logic [4:0] req5;
  logic [4:0] lock5;
  logic       rdy5;
  logic       v5;
  logic [4:0] oh5;
  logic [2:0] idx5;
  logic [2:0] ptr5;

  int checks;
  int passes;
  int fails;

  rr_issue_arbiter #(.N(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req4),
`ifdef RR_ARB_LOCK_EN
    .lock_i       (lock4),
`endif
    .gnt_ready_i  (rdy4),
    .gnt_valid_o  (v4),
    .gnt_onehot_o (oh4),
    .gnt_idx_o    (idx4),
    .rr_ptr_o     (ptr4)
  );

  rr_issue_arbiter #(.N(5)) u_dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req5),
`ifdef RR_ARB_LOCK_EN
    .lock_i       (lock5),
`endif
    .gnt_ready_i  (rdy5),
    .gnt_valid_o  (v5),
    .gnt_onehot_o (oh5),
    .gnt_idx_o    (idx5),
    .rr_ptr_o     (ptr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic v, input logic [1:0] i,
                      input logic [3:0] o, input logic [1:0] p);
    chk({tag, ".valid"}, {7'd0, v4}, {7'd0, v});
    chk({tag, ".idx"}, {6'd0, idx4}, {6'd0, i});
    chk({tag, ".onehot"}, {4'd0, oh4}, {4'd0, o});
    chk({tag, ".ptr"}, {6'd0, ptr4}, {6'd0, p});
  endtask

  task automatic chk5(input string tag, input logic v, input logic [2:0] i,
                      input logic [4:0] o, input logic [2:0] p);
    chk({tag, ".valid"}, {7'd0, v5}, {7'd0, v});
    chk({tag, ".idx"}, {5'd0, idx5}, {5'd0, i});
    chk({tag, ".onehot"}, {3'd0, oh5}, {3'd0, o});
    chk({tag, ".ptr"}, {5'd0, ptr5}, {5'd0, p});
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    rst_n  = 1'b0;
    req4   = '0;
    lock4  = '0;
    rdy4   = 1'b0;
    req5   = '0;
    lock5  = '0;
    rdy5   = 1'b0;

    // reset held 3 cycles
    repeat (3) tick();
    chk4("rst_hold", 1'b0, 2'd0, 4'b0000, 2'd0);
    rst_n = 1'b1;
    tick();
    chk4("rst_idle", 1'b0, 2'd0, 4'b0000, 2'd0);

    // single request
    req4 = 4'b0100;
    tick();
    chk4("single_gnt", 1'b1, 2'd2, 4'b0100, 2'd0);
    rdy4 = 1'b1;
    req4 = 4'b0000;
    tick();
    chk4("single_fire", 1'b0, 2'd0, 4'b0000, 2'd3);

    // full rotation from reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req4  = 4'b1111;
    rdy4  = 1'b1;
    tick();
    chk4("rot0", 1'b1, 2'd0, 4'b0001, 2'd0);
    tick();
    chk4("rot1", 1'b1, 2'd1, 4'b0010, 2'd1);
    tick();
    chk4("rot2", 1'b1, 2'd2, 4'b0100, 2'd2);
    tick();
    chk4("rot3", 1'b1, 2'd3, 4'b1000, 2'd3);
    tick();
    chk4("rot4", 1'b1, 2'd0, 4'b0001, 2'd0);
    tick();
    chk4("rot5", 1'b1, 2'd1, 4'b0010, 2'd1);

    // asynchronous reset mid-grant, no clock edge
    rst_n = 1'b0;
    rdy4  = 1'b0;
    req4  = 4'b0000;
    #1;
    chk4("async_rst", 1'b0, 2'd0, 4'b0000, 2'd0);
    rst_n = 1'b1;

    // backpressure
    req4 = 4'b0011;
    tick();
    chk4("bp_gnt", 1'b1, 2'd0, 4'b0001, 2'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req4 = 4'b0010;
      tick();
      chk4("bp_hold", 1'b1, 2'd0, 4'b0001, 2'd0);
    end
    rdy4 = 1'b1;
    tick();
    chk4("bp_fire", 1'b1, 2'd1, 4'b0010, 2'd1);
    req4 = 4'b0000;
    tick();
    chk4("bp_drain", 1'b0, 2'd0, 4'b0000, 2'd2);
    tick();
    chk4("rdy_idle", 1'b0, 2'd0, 4'b0000, 2'd2);

    // wrap-around, N=5
    rdy4 = 1'b0;
    req5 = 5'b01000;
    tick();
    chk5("w_g3", 1'b1, 3'd3, 5'b01000, 3'd0);
    rdy5 = 1'b1;
    req5 = 5'b00000;
    tick();
    chk5("w_p4", 1'b0, 3'd0, 5'b00000, 3'd4);
    rdy5 = 1'b0;
    req5 = 5'b00011;
    tick();
    chk5("w_g0", 1'b1, 3'd0, 5'b00001, 3'd4);
    req5 = 5'b10000;
    rdy5 = 1'b1;
    tick();
    chk5("w_g4", 1'b1, 3'd4, 5'b10000, 3'd1);
    req5 = 5'b00000;
    tick();
    chk5("w_p0", 1'b0, 3'd0, 5'b00000, 3'd0);
    rdy5 = 1'b0;

`ifdef RR_ARB_LOCK_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req4  = 4'b0011;
    lock4 = 4'b0001;
    rdy4  = 1'b1;
    tick();
    chk4("lk_g", 1'b1, 2'd0, 4'b0001, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("lk_hold", 1'b1, 2'd0, 4'b0001, 2'd0);
    end
    lock4 = 4'b0000;
    tick();
    chk4("lk_rel", 1'b1, 2'd1, 4'b0010, 2'd1);
    rdy4 = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_issue_arbiter.md
# rr_issue_arbiter

Round-robin arbiter sharing one downstream resource (issue port, CDB slot, memory port) among N requesters in the MIPS core. Each cycle it selects the first active request at or after a rotating priority pointer, which is a rotated bottom-up priority encode. It registers the winner as a one-hot plus index grant and holds it under a valid/ready handshake until the resource accepts it. Fairness: the pointer advances past each accepted winner, so no active requester waits more than N-1 accepted grants.

## Interface
- `N`, default 8: number of requesters, 2..64, need not be a power of two.
- `IDX_W`, default `$clog2(N)`: width of the grant index.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester request; bit i is requester i.
- `lock`  in  N  per-requester lock hint; present only with `RR_ARB_LOCK_EN`.
- `gnt_ready`  in  1  the resource accepts the current grant this cycle.
- `gnt_valid`  out  1  a grant is presented.
- `gnt_onehot`  out  N  one-hot grant; all zero when `gnt_valid`=0.
- `gnt_idx`  out  IDX_W  index of the granted requester; 0 when `gnt_valid`=0.
- `rr_ptr`  out  IDX_W  current priority pointer, for debug and coverage.

## Operation
- **Reset:** one clock; reset is asynchronous and active-low. Reset forces `gnt_valid`=0, `gnt_onehot`=0, `gnt_idx`=0, `rr_ptr`=0 and state IDLE immediately, mid-grant included. Any grant pending at reset is dropped.
- **Fire:** `gnt_valid` && `gnt_ready`.
- **Winner selection:** combinational. Winner w is the lowest i in the order `rr_ptr`, `rr_ptr`+1, …, N-1, 0, …, `rr_ptr`-1 with `req[i]`=1. Index arithmetic is modulo N, with an explicit wrap N-1 → 0 for non-power-of-two N.
- **State IDLE** (`gnt_valid`=0):
  - If `|req`, register w and go to GRANT.
  - Otherwise stay in IDLE.
- **State GRANT** (`gnt_valid`=1): `gnt_onehot` and `gnt_idx` hold stable until fire, whatever `req` does.
  - **Pointer on fire:** `rr_ptr` ← (`gnt_idx`+1) mod N.
  - **Next grant on fire:** recompute the winner over `req` from the new pointer in the same cycle.
  - If that winner exists, register it and stay in GRANT (back-to-back, one grant per cycle).
  - If no winner exists, go to IDLE.
  - **No fire:** no state change.
- **Request rules:**
  - A requester holds `req` until it sees its grant fire.
  - If it drops `req` while granted, the grant still completes. The requester discards it.
  - `gnt_ready` while `gnt_valid`=0 is ignored.
- **Invariants:**
  - `gnt_onehot` has at most one bit set.
  - `gnt_onehot` == (1 << `gnt_idx`) whenever `gnt_valid`=1.
  - `rr_ptr` < N always.

## Timing
- **Request to grant:** `req` rising in cycle t with the arbiter in IDLE gives `gnt_valid`=1 in t+1. Registered output; no combinational path from `req` to any output.
- **Throughput:** one grant per cycle when `gnt_ready` is held high and requests persist.
- **Fire to next grant:** fire in cycle t presents the next grant in t+1. `gnt_valid` drops in t+1 if there is no pending request.
- **Simultaneous events:** a requester that asserts `req` in the fire cycle takes part in that cycle's selection.
- **Fairness:** with all N requesters held high and `gnt_ready`=1, grants cycle through 0..N-1 in order, starting from `rr_ptr`.

## Configuration
- **`RR_ARB_LOCK_EN` defined:**
  - Port `lock` exists.
  - On fire with `lock[gnt_idx]`=1 and `req[gnt_idx]`=1: the next grant goes to the same requester, and `rr_ptr` is not advanced.
  - The first fire with `lock[gnt_idx]`=0 applies the normal pointer update.
  - Used for multi-beat transfers.
- **`RR_ARB_LOCK_EN` undefined:**
  - No `lock` port.
  - The pointer always advances on fire.

## Test plan
- **Reset:** N=4, hold `rst_n`=0 for 3 cycles, then release → all outputs 0 and IDLE. Assert `rst_n`=0 mid-grant → `gnt_valid`=0 in the same cycle, no clock edge needed.
- **Single request:** `req`=4'b0100 in IDLE → next cycle `gnt_valid`=1, `gnt_idx`=2, `gnt_onehot`=4'b0100. Fire → `rr_ptr`=3.
- **Full rotation:** `req`=4'b1111 held, `gnt_ready`=1 from reset → `gnt_idx` sequence 0,1,2,3,0, then `rr_ptr`=1.
- **Backpressure:** `req`=4'b0011, `gnt_ready`=0 for 5 cycles → `gnt_idx`=0 stable for all 5 even if `req` changes to 4'b0010. Then `gnt_ready`=1 → fire, and the next grant is idx 1.
- **Wrap-around:** N=5, `rr_ptr`=4, `req`=5'b00011 → grant idx 0. Then `req`=5'b10000 → grant idx 4. Fire → `rr_ptr`=0.
- **Lock** (`RR_ARB_LOCK_EN`): `req`=4'b0011, `lock`=4'b0001 for 3 fires → idx 0,0,0. Clear `lock` → next idx 1.
